// File: rtl/fifo_burst_reader_pkg.sv
// Shared state encoding and width helpers for the FIFO burst reader.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_out_reg.sv
// Single-entry output register for the burst stream; holds its word while the
// consumer stalls and reports when a new word may be loaded.
module fifo_burst_out_reg #(
  parameter int DATA_BIT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [DATA_BIT-1:0] i_data,
  input  logic                i_sop,
  input  logic                i_eop,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_sop,
  output logic                o_eop,
  output logic                o_can_load
);

  logic                r_valid;
  logic [DATA_BIT-1:0] r_data;
  logic                r_sop;
  logic                r_eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_can_load = !r_valid || i_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_sop      = r_sop;
  assign o_eop      = r_eop;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst drain controller for a FWFT FIFO.
// Optional burst statistics counters: define FIFO_BURST_READER_STAT_EN.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_BIT   = 16,
  parameter int DATA_DEPTH = 4,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                           rd_clk,
  input  logic                           rst_n,
  input  logic [DATA_BIT-1:0]            fifo_rd_data,
  input  logic                           fifo_empty,
  input  logic [DATA_DEPTH-1:0]          fifo_rd_cnt,
  output logic                           fifo_rd_en,
  output logic [DATA_BIT-1:0]            m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_sop,
  output logic                           m_eop,
  output logic [$clog2(BURST_LEN):0]     m_len,
`ifdef FIFO_BURST_READER_STAT_EN
  output logic [STAT_W-1:0]              stat_full,
  output logic [STAT_W-1:0]              stat_short,
`endif
  output logic                           busy
);

  localparam int LEN_W  = $clog2(BURST_LEN) + 1;
  localparam int TMR_W  = cnt_w(TIMEOUT);
  localparam int CNT_LO = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int AV_W   = CNT_LO + 1;

  state_t             r_state, w_state_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic [LEN_W-1:0]   r_rem, w_rem_nxt;
  logic [CNT_LO-1:0]  w_cnt_lo;
  logic [AV_W-1:0]    w_avail;
  logic               w_can_load;
  logic               w_pop;
  logic               w_eop_acc;
  logic               w_unused_cnt;

  // Occupancy reads 0 when the FIFO is full, so a non-empty zero means DATA_DEPTH.
  assign w_cnt_lo     = fifo_rd_cnt[CNT_LO-1:0];
  assign w_avail      = (!fifo_empty && (w_cnt_lo == '0)) ? AV_W'(DATA_DEPTH)
                                                          : {1'b0, w_cnt_lo};
  assign w_unused_cnt = ^fifo_rd_cnt;

  assign w_pop     = (r_state == ST_BURST) && (r_rem != '0) && !fifo_empty && w_can_load;
  assign w_eop_acc = m_valid && m_ready && m_eop;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_len_nxt   = r_len;
    w_rem_nxt   = r_rem;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (!fifo_empty) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (r_timer != TMR_W'(TIMEOUT)) w_timer_nxt = r_timer + 1'b1;
        if (w_avail >= AV_W'(BURST_LEN)) begin
          w_state_nxt = ST_BURST;
          w_len_nxt   = LEN_W'(BURST_LEN);
          w_rem_nxt   = LEN_W'(BURST_LEN);
        end else if ((r_timer == TMR_W'(TIMEOUT - 1)) && (w_avail != '0)) begin
          w_state_nxt = ST_BURST;
          w_len_nxt   = LEN_W'(w_avail);
          w_rem_nxt   = LEN_W'(w_avail);
        end else if (fifo_empty) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (w_pop) w_rem_nxt = r_rem - 1'b1;
        // Leave only once the last word has actually been taken downstream.
        if ((r_rem == '0) && w_eop_acc) begin
          w_timer_nxt = '0;
          w_state_nxt = fifo_empty ? ST_IDLE : ST_ARM;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_len   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_len   <= w_len_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  fifo_burst_out_reg #(
    .DATA_BIT (DATA_BIT)
  ) u_out_reg (
    .clk        (rd_clk),
    .rst_n      (rst_n),
    .i_load     (w_pop),
    .i_data     (fifo_rd_data),
    .i_sop      (r_rem == r_len),
    .i_eop      (r_rem == LEN_W'(1)),
    .i_ready    (m_ready),
    .o_valid    (m_valid),
    .o_data     (m_data),
    .o_sop      (m_sop),
    .o_eop      (m_eop),
    .o_can_load (w_can_load)
  );

  assign fifo_rd_en = w_pop;
  assign m_len      = r_len;
  assign busy       = (r_state == ST_ARM) || (r_state == ST_BURST);

`ifdef FIFO_BURST_READER_STAT_EN
  logic [STAT_W-1:0] r_stat_full;
  logic [STAT_W-1:0] r_stat_short;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_full  <= '0;
      r_stat_short <= '0;
    end else if (w_eop_acc) begin
      if (r_len == LEN_W'(BURST_LEN)) begin
        if (r_stat_full != STAT_MAX) r_stat_full <= r_stat_full + 1'b1;
      end else begin
        if (r_stat_short != STAT_MAX) r_stat_short <= r_stat_short + 1'b1;
      end
    end
  end

  assign stat_full  = r_stat_full;
  assign stat_short = r_stat_short;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO model, random data/ready, burst scoreboard.
module tb_fifo_burst_reader;

  localparam int DATA_BIT   = 16;
  localparam int DATA_DEPTH = 4;
  localparam int BURST_LEN  = 4;
  localparam int TIMEOUT    = 15;
  localparam int LEN_W      = $clog2(BURST_LEN) + 1;
  localparam int CNT_LO     = $clog2(DATA_DEPTH);

  logic                  rd_clk;
  logic                  rst_n;
  logic [DATA_BIT-1:0]   fifo_rd_data;
  logic                  fifo_empty;
  logic [DATA_DEPTH-1:0] fifo_rd_cnt;
  logic                  fifo_rd_en;
  logic [DATA_BIT-1:0]   m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_sop;
  logic                  m_eop;
  logic [LEN_W-1:0]      m_len;
  logic                  busy;
`ifdef FIFO_BURST_READER_STAT_EN
  logic [15:0]           stat_full;
  logic [15:0]           stat_short;
`endif

  fifo_burst_reader #(
    .DATA_BIT   (DATA_BIT),
    .DATA_DEPTH (DATA_DEPTH),
    .BURST_LEN  (BURST_LEN),
    .TIMEOUT    (TIMEOUT)
  ) dut (
`ifdef FIFO_BURST_READER_STAT_EN
    .stat_full    (stat_full),
    .stat_short   (stat_short),
`endif
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_cnt  (fifo_rd_cnt),
    .fifo_rd_en   (fifo_rd_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_sop        (m_sop),
    .m_eop        (m_eop),
    .m_len        (m_len),
    .busy         (busy)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic [DATA_BIT-1:0] data;
    logic                sop;
    logic                eop;
    logic [LEN_W-1:0]    len;
  } beat_t;

  beat_t               exp_q[$];
  logic [DATA_BIT-1:0] fifo_q[$];
  logic [DATA_BIT-1:0] wr_q[$];

  int    checks = 0;
  int    errors = 0;
  int    exp_full = 0, exp_short = 0;
  int    ready_pct = 100;
  int    stall_cnt = 0;
  bit    stall_on_sop = 0, stall_active = 0;
  int    stall_pops = 0, hold_cycles = 0;
  bit    arm_track = 0, track_first = 0;
  int    since_nonempty = 0, first_pop_delay = -1;
  int    pops = 0, accepted = 0, cyc = 0, sop_cyc = 0, eop_cyc = 0;
  bit    rd_seen = 0, prev_hold = 0, prev_eop_acc = 0;
  beat_t prev_beat;

  // Writes are split into bursts of BURST_LEN in order; any remainder leaves as one short burst.
  task automatic push_words(input int n, input logic [DATA_BIT-1:0] base, input bit rnd);
    beat_t b;
    int    start, l;
    for (int i = 0; i < n; i++) begin
      b.data = rnd ? DATA_BIT'($urandom) : base + DATA_BIT'(i);
      start  = (i / BURST_LEN) * BURST_LEN;
      l      = (n - start < BURST_LEN) ? (n - start) : BURST_LEN;
      b.sop  = (i == start);
      b.eop  = (i == start + l - 1);
      b.len  = LEN_W'(l);
      if (b.eop) begin
        if (l == BURST_LEN) exp_full++;
        else exp_short++;
      end
      wr_q.push_back(b.data);
      exp_q.push_back(b);
    end
  endtask

  task automatic observe();
    beat_t b;
    rd_seen = fifo_rd_en;
    cyc++;
    if (fifo_rd_en === 1'b1) begin
      pops++;
      checks++;
      if (fifo_empty !== 1'b0) begin
        errors++;
        $display("FAIL rd_en_when_empty: fifo_empty=%0b, required 0", fifo_empty);
      end
      checks++;
      if (m_valid === 1'b1 && m_ready === 1'b0) begin
        errors++;
        $display("FAIL pop_while_stalled: fifo_rd_en=1, required 0");
      end
      if (stall_active) stall_pops++;
    end
    if (prev_hold) begin
      hold_cycles++;
      checks++;
      if (m_valid !== 1'b1 || m_data !== prev_beat.data || m_sop !== prev_beat.sop ||
          m_eop !== prev_beat.eop || m_len !== prev_beat.len) begin
        errors++;
        $display("FAIL hold: v=%0b d=%h s=%0b e=%0b l=%0d, required v=1 d=%h s=%0b e=%0b l=%0d",
                 m_valid, m_data, m_sop, m_eop, m_len,
                 prev_beat.data, prev_beat.sop, prev_beat.eop, prev_beat.len);
      end
    end
    if (prev_eop_acc) begin
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL gap_after_eop: m_valid=%0b, required 0", m_valid);
      end
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      accepted++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: d=%h s=%0b e=%0b, required no beat", m_data, m_sop, m_eop);
      end else begin
        b = exp_q.pop_front();
        if (m_data !== b.data || m_sop !== b.sop || m_eop !== b.eop || m_len !== b.len) begin
          errors++;
          $display("FAIL beat: d=%h s=%0b e=%0b l=%0d, required d=%h s=%0b e=%0b l=%0d",
                   m_data, m_sop, m_eop, m_len, b.data, b.sop, b.eop, b.len);
        end
      end
      if (m_sop === 1'b1) sop_cyc = cyc;
      if (m_eop === 1'b1) eop_cyc = cyc;
      if (stall_on_sop && m_sop === 1'b1) begin
        stall_cnt    = 5;
        stall_on_sop = 0;
      end
    end
    if (track_first) begin
      since_nonempty++;
      if (fifo_rd_en === 1'b1) begin
        first_pop_delay = since_nonempty;
        track_first     = 0;
      end
    end
    prev_hold    = (m_valid === 1'b1 && m_ready === 1'b0);
    prev_beat    = '{m_data, m_sop, m_eop, m_len};
    prev_eop_acc = (m_valid === 1'b1 && m_ready === 1'b1 && m_eop === 1'b1);
  endtask

  task automatic drive();
    logic [DATA_DEPTH-1:0] c;
    logic [DATA_BIT-1:0]   tmp;
    bit                    was_empty;
    if (rd_seen && fifo_q.size() > 0) tmp = fifo_q.pop_front();
    rd_seen   = 0;
    was_empty = (fifo_q.size() == 0);
    if (fifo_q.size() < DATA_DEPTH && wr_q.size() > 0) begin
      fifo_q.push_back(wr_q.pop_front());
      if (was_empty && arm_track) begin
        track_first    = 1;
        since_nonempty = 0;
        arm_track      = 0;
      end
    end
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : DATA_BIT'($urandom);
    c = DATA_DEPTH'($urandom);
    c[CNT_LO-1:0] = CNT_LO'(fifo_q.size());
    fifo_rd_cnt = c;
    if (stall_cnt > 0) begin
      m_ready      = 1'b0;
      stall_active = 1;
      stall_cnt--;
    end else begin
      stall_active = 0;
      m_ready      = ($urandom_range(0, 99) < ready_pct);
    end
  endtask

  task automatic cycle();
    @(negedge rd_clk);
    observe();
    @(posedge rd_clk);
    #1;
    drive();
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      cycle();
      if (exp_q.size() == 0 && wr_q.size() == 0 && fifo_q.size() == 0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: %0d beats pending, required 0", name, exp_q.size());
    end
    cycle();
    cycle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fifo_empty = 1'b1; fifo_rd_cnt = '0; fifo_rd_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1;
    checks++;
    if ({m_valid, m_sop, m_eop, busy, fifo_rd_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: v/s/e/busy/rd=%b, required 00000", {m_valid, m_sop, m_eop, busy, fifo_rd_en});
    end
    checks++;
    if (m_data !== '0 || m_len !== '0) begin
      errors++;
      $display("FAIL reset_data: m_data=%h m_len=%0d, required 0 0", m_data, m_len);
    end
`ifdef FIFO_BURST_READER_STAT_EN
    checks++;
    if (stat_full !== 16'd0 || stat_short !== 16'd0) begin
      errors++;
      $display("FAIL reset_stat: full=%0d short=%0d, required 0 0", stat_full, stat_short);
    end
`endif
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_full_burst();
    ready_pct = 100;
    pops      = 0;
    push_words(4, 16'hA0, 0);
    drain("full_burst");
    checks++;
    if (pops != 4) begin
      errors++;
      $display("FAIL full_burst_pops: %0d, required 4", pops);
    end
    checks++;
    if (eop_cyc - sop_cyc != 3) begin
      errors++;
      $display("FAIL full_burst_spacing: %0d cycles sop->eop, required 3", eop_cyc - sop_cyc);
    end
  endtask

  task automatic test_timeout();
    ready_pct       = 100;
    first_pop_delay = -1;
    arm_track       = 1;
    push_words(2, 16'hB0, 0);
    drain("timeout");
    // One cycle for IDLE to see the word, then TIMEOUT ARM cycles before the first pop.
    checks++;
    if (first_pop_delay != TIMEOUT + 2) begin
      errors++;
      $display("FAIL timeout_delay: first pop after %0d cycles, required %0d", first_pop_delay, TIMEOUT + 2);
    end
  endtask

  task automatic test_back_to_back();
    ready_pct = 100;
    pops      = 0;
    push_words(8, '0, 1);
    drain("back_to_back");
    checks++;
    if (pops != 8) begin
      errors++;
      $display("FAIL back_to_back_pops: %0d, required 8", pops);
    end
  endtask

  task automatic test_stall();
    ready_pct    = 100;
    stall_pops   = 0;
    hold_cycles  = 0;
    stall_on_sop = 1;
    push_words(4, '0, 1);
    drain("stall");
    checks++;
    if (stall_pops != 0) begin
      errors++;
      $display("FAIL stall_pops: %0d, required 0", stall_pops);
    end
    checks++;
    if (hold_cycles != 5) begin
      errors++;
      $display("FAIL stall_hold: %0d held cycles, required 5", hold_cycles);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      ready_pct = $urandom_range(30, 100);
      push_words($urandom_range(1, 11), '0, 1);
      drain("random");
    end
  endtask

  task automatic test_stats(input bit fixed);
`ifdef FIFO_BURST_READER_STAT_EN
    checks++;
    if (stat_full !== 16'(exp_full) || stat_short !== 16'(exp_short)) begin
      errors++;
      $display("FAIL stats: full=%0d short=%0d, required %0d %0d", stat_full, stat_short, exp_full, exp_short);
    end
    if (fixed) begin
      checks++;
      if (stat_full !== 16'd3 || stat_short !== 16'd1) begin
        errors++;
        $display("FAIL stats_fixed: full=%0d short=%0d, required 3 1", stat_full, stat_short);
      end
    end
`else
    if (fixed) exp_full = exp_full + 0;
`endif
  endtask

  task automatic test_reset_mid();
    int  base;
    bit  hit = 0;
    ready_pct = 100;
    base      = accepted;
    push_words(4, '0, 1);
    for (int i = 0; i < 100 && !hit; i++) begin
      cycle();
      if (accepted - base >= 2) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_start: %0d beats seen, required 2", accepted - base);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_sop, m_eop, busy, fifo_rd_en} !== 5'b0 || m_data !== '0 || m_len !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: v/s/e/busy/rd=%b d=%h l=%0d, required all 0",
               {m_valid, m_sop, m_eop, busy, fifo_rd_en}, m_data, m_len);
    end
    exp_q.delete(); wr_q.delete(); fifo_q.delete();
    exp_full = 0; exp_short = 0;
    fifo_empty = 1'b1; fifo_rd_cnt = '0;
    rd_seen = 0; prev_hold = 0; prev_eop_acc = 0;
    repeat (2) @(posedge rd_clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (m_valid !== 1'b0 || m_eop !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle: v=%0b e=%0b busy=%0b, required 0 0 0", m_valid, m_eop, busy);
      end
    end
    test_stats(0);
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_timeout();
    test_back_to_back();
    test_stats(1);
    test_stall();
    test_random();
    test_stats(0);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
